// File: rtl/pu_io_req_master_pkg.sv
// Shared types and widths for the PU I/O read-request master.
package pu_io_req_master_pkg;

  localparam int unsigned PU_WIDTH_NBITS = 16;
  localparam int unsigned PU_ADDR_NBITS  = 32;

  typedef struct packed {
    logic [PU_ADDR_NBITS-1:0] addr;
    logic [1:0]               size;
  } io_type;

endpackage

// File: rtl/sfifo2f_fo.sv
// Two-entry synchronous FIFO with fall-through output; push+pop while full is allowed.
module sfifo2f_fo #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_pop   = i_pop && (r_cnt != 2'd0);
  assign w_push  = i_push && ((r_cnt != 2'd2) || w_pop);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pu_io_req_master.sv
// Queues core reads and issues them one at a time to the memory responder,
// with an optional acknowledge timeout and a count of discarded late acks.
module pu_io_req_master
  import pu_io_req_master_pkg::*;
#(
  parameter int unsigned WIDTH_NBITS = PU_WIDTH_NBITS,
  parameter int unsigned TMO_NBITS   = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   core_rd,
  input  io_type                 core_cmd,
  output logic                   core_ready,
  output logic                   io_req,
  output io_type                 io_cmd,
  input  logic                   io_ack,
  input  logic [WIDTH_NBITS-1:0] io_ack_data,
  output logic                   core_rvalid,
  output logic [WIDTH_NBITS-1:0] core_rdata,
  output logic                   core_rerr,
  input  logic [TMO_NBITS-1:0]   cfg_timeout,
  output logic [7:0]             stale_ack_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_QUIESCE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  io_type                 r_io_cmd;
  io_type                 w_q_head;
  logic                   r_io_req;
  logic                   r_rvalid;
  logic [WIDTH_NBITS-1:0] r_rdata;
  logic                   r_rerr;
  logic [TMO_NBITS-1:0]   r_tmo_cnt;
  logic [7:0]             r_stale_cnt;
  logic                   w_q_full;
  logic                   w_q_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_tmo_exp;
  logic                   w_cpl_ok;
  logic                   w_cpl_err;
  logic                   w_stale;
  logic                   w_tmo_clr;

  assign core_ready    = ~w_q_full;
  assign w_push        = core_rd && ~w_q_full;
  assign io_req        = r_io_req;
  assign io_cmd        = r_io_cmd;
  assign core_rvalid   = r_rvalid;
  assign core_rdata    = r_rdata;
  assign core_rerr     = r_rerr;
  assign stale_ack_cnt = r_stale_cnt;
  assign w_tmo_exp     = (cfg_timeout != '0) &&
                         (r_tmo_cnt == (cfg_timeout - TMO_NBITS'(1)));

  sfifo2f_fo #(
    .DW ($bits(io_type))
  ) u_cmd_q (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_din   (core_cmd),
    .i_pop   (w_pop),
    .o_dout  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (!w_q_empty) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_WAIT;
      ST_WAIT: begin
        // An ack coinciding with expiry takes priority over the timeout.
        if (io_ack)         w_next_state = ST_IDLE;
        else if (w_tmo_exp) w_next_state = ST_QUIESCE;
      end
      ST_QUIESCE: if (io_ack || w_tmo_exp) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_cpl_ok  = 1'b0;
    w_cpl_err = 1'b0;
    w_stale   = 1'b0;
    w_tmo_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop     = ~w_q_empty;
        w_stale   = io_ack;
        w_tmo_clr = 1'b1;
      end
      ST_ISSUE: begin
        w_stale   = io_ack;
        w_tmo_clr = 1'b1;
      end
      ST_WAIT: begin
        w_cpl_ok  = io_ack;
        w_cpl_err = ~io_ack && w_tmo_exp;
        w_tmo_clr = ~io_ack && w_tmo_exp;
      end
      ST_QUIESCE: w_stale = io_ack;
      default:    w_tmo_clr = 1'b1;
    endcase
  end

  // Registered datapath: request pulse, command hold, completion and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_io_req    <= 1'b0;
      r_io_cmd    <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rerr      <= 1'b0;
      r_tmo_cnt   <= '0;
      r_stale_cnt <= 8'd0;
    end else begin
      r_io_req <= w_pop;
      if (w_pop) r_io_cmd <= w_q_head;
      r_rvalid <= w_cpl_ok || w_cpl_err;
      r_rdata  <= w_cpl_ok ? io_ack_data : '0;
      r_rerr   <= w_cpl_err;
      if (w_tmo_clr)                      r_tmo_cnt <= '0;
      else if (r_tmo_cnt != {TMO_NBITS{1'b1}}) r_tmo_cnt <= r_tmo_cnt + TMO_NBITS'(1);
      if (w_stale && (r_stale_cnt != 8'hFF)) r_stale_cnt <= r_stale_cnt + 8'd1;
    end
  end

endmodule
